// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable clock-enable divider with a
// glitch-free ratio-change sequencer (RUN / DRAIN / LOCK).
// Optional macro CLK_DIV_CTRL_GATE_EN: suppress o_clk_en/o_div_clk while unlocked.
module clk_div_ctrl #(
  parameter int CNT_W       = 8,
  parameter int DIV_DEFAULT = 2,
  parameter int LOCK_CYCLES = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_cfg_req,
  input  logic [CNT_W-1:0] i_cfg_div,
  output logic             o_cfg_ack,
  output logic             o_cfg_err,
  output logic             o_clk_en,
  output logic             o_div_clk,
  output logic             o_locked,
  output logic             o_busy
);

  localparam int LCK_W =
    (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

  localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_DEFAULT);
  localparam logic [CNT_W-1:0] C_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] C_TWO   = CNT_W'(2);
  localparam logic [LCK_W-1:0] L_ONE   = LCK_W'(1);
  localparam logic [LCK_W-1:0] L_LAST  =
    LCK_W'((LOCK_CYCLES > 0) ? (LOCK_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_DRAIN = 2'd1,
    S_LOCK  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] r_div;
  logic [CNT_W-1:0] w_div_nxt;
  logic [CNT_W-1:0] r_pend;
  logic [CNT_W-1:0] w_pend_nxt;
  logic [LCK_W-1:0] r_lck;
  logic [LCK_W-1:0] w_lck_nxt;
  logic             r_from_drain;
  logic             w_from_drain_nxt;
  logic             r_locked;
  logic             w_locked_nxt;
  logic             r_ack;
  logic             w_ack_nxt;
  logic             r_err;
  logic             w_err_nxt;
  logic             r_busy;
  logic             r_en;
  logic             r_dclk;
  logic             w_wrap;
  logic             w_req_ok;
  logic             w_lock_done;
  logic [CNT_W-1:0] w_half;
  logic [CNT_W-1:0] w_thr;
  logic             w_en_nxt;
  logic             w_dclk_nxt;

  assign w_wrap   = (r_cnt == (r_div - C_ONE));
  assign w_req_ok = (i_cfg_div >= C_TWO);

  // LOCK exit: immediately when no settle is needed, else on the last strobe
  always_comb begin
    w_lock_done = 1'b0;
    if (LOCK_CYCLES == 0) begin
      w_lock_done = 1'b1;
    end else begin
      w_lock_done = r_en && (r_lck == L_LAST);
    end
  end

  // next-state, counter and handshake decode
  always_comb begin
    w_state_nxt      = r_state;
    w_cnt_nxt        = w_wrap ? '0 : (r_cnt + C_ONE);
    w_div_nxt        = r_div;
    w_pend_nxt       = r_pend;
    w_lck_nxt        = r_lck;
    w_from_drain_nxt = r_from_drain;
    w_locked_nxt     = r_locked;
    w_ack_nxt        = 1'b0;
    w_err_nxt        = 1'b0;
    unique case (r_state)
      S_RUN: begin
        if (i_cfg_req) begin
          if (w_req_ok) begin
            w_pend_nxt  = i_cfg_div;
            w_state_nxt = S_DRAIN;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (w_wrap) begin
          w_div_nxt        = r_pend;
          w_cnt_nxt        = '0;
          w_locked_nxt     = 1'b0;
          w_lck_nxt        = '0;
          w_from_drain_nxt = 1'b1;
          w_state_nxt      = S_LOCK;
        end
      end
      S_LOCK: begin
        if (w_lock_done) begin
          w_locked_nxt     = 1'b1;
          w_ack_nxt        = r_from_drain;
          w_from_drain_nxt = 1'b0;
          w_state_nxt      = S_RUN;
        end else if (r_en) begin
          w_lck_nxt = r_lck + L_ONE;
        end
      end
      default: begin
        w_state_nxt = S_LOCK;
      end
    endcase
  end

  // strobe and divided-clock decode from the next counter value
  always_comb begin
    w_half     = w_div_nxt >> 1;
    w_thr      = w_div_nxt - w_half;
    w_en_nxt   = (w_cnt_nxt == (w_div_nxt - C_ONE));
    w_dclk_nxt = (w_cnt_nxt >= w_thr);
  end

  // sequencer and counter state
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_LOCK;
      r_cnt        <= '0;
      r_div        <= DIV_RST;
      r_pend       <= DIV_RST;
      r_lck        <= '0;
      r_from_drain <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_div        <= w_div_nxt;
      r_pend       <= w_pend_nxt;
      r_lck        <= w_lck_nxt;
      r_from_drain <= w_from_drain_nxt;
    end
  end

  // registered status and divider outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_locked <= 1'b0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b1;
      r_en     <= 1'b0;
      r_dclk   <= 1'b0;
    end else begin
      r_locked <= w_locked_nxt;
      r_ack    <= w_ack_nxt;
      r_err    <= w_err_nxt;
      r_busy   <= (w_state_nxt != S_RUN);
      r_en     <= w_en_nxt;
      r_dclk   <= w_dclk_nxt;
    end
  end

`ifdef CLK_DIV_CTRL_GATE_EN
  logic r_en_g;
  logic r_dclk_g;

  // gated copies: silent whenever the next lock flag is low
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_en_g   <= 1'b0;
      r_dclk_g <= 1'b0;
    end else begin
      r_en_g   <= w_en_nxt & w_locked_nxt;
      r_dclk_g <= w_dclk_nxt & w_locked_nxt;
    end
  end

  assign o_clk_en  = r_en_g;
  assign o_div_clk = r_dclk_g;
`else
  assign o_clk_en  = r_en;
  assign o_div_clk = r_dclk;
`endif

  assign o_cfg_ack = r_ack;
  assign o_cfg_err = r_err;
  assign o_locked  = r_locked;
  assign o_busy    = r_busy;

endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: scoreboard bench for clk_div_ctrl.
// Expected per-cycle outputs are queued with stimulus, popped at negedge.
module tb_clk_div_ctrl;

  localparam int CNT_W = 8;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_cfg_req;
  logic [CNT_W-1:0] i_cfg_div;
  logic             o_cfg_ack;
  logic             o_cfg_err;
  logic             o_clk_en;
  logic             o_div_clk;
  logic             o_locked;
  logic             o_busy;

  clk_div_ctrl #(
    .CNT_W(CNT_W),
    .DIV_DEFAULT(2),
    .LOCK_CYCLES(4)
  ) u_dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_cfg_req(i_cfg_req),
    .i_cfg_div(i_cfg_div),
    .o_cfg_ack(o_cfg_ack),
    .o_cfg_err(o_cfg_err),
    .o_clk_en (o_clk_en),
    .o_div_clk(o_div_clk),
    .o_locked (o_locked),
    .o_busy   (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic en;
    logic dclk;
    logic lk;
    logic bz;
    logic ack;
    logic err;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // queue n cycles of a divider running ratio d from count c0
  task automatic gen(input int d, input int c0, input int n,
                     input logic lk, input logic bz,
                     input logic ack1, input logic err1);
    int   c;
    exp_t e;
    c = c0;
    for (int i = 0; i < n; i++) begin
      e.en   = (c == d - 1);
      e.dclk = (c >= d - d / 2);
`ifdef CLK_DIV_CTRL_GATE_EN
      if (!lk) begin
        e.en   = 1'b0;
        e.dclk = 1'b0;
      end
`endif
      e.lk  = lk;
      e.bz  = bz;
      e.ack = (i == 0) && ack1;
      e.err = (i == 0) && err1;
      sb_q.push_back(e);
      c = (c == d - 1) ? 0 : c + 1;
    end
  endtask

  task automatic cmp_one();
    exp_t e;
    chk($sformatf("c%0d sb_avail", cyc), 32'(sb_q.size() > 0), 1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk($sformatf("c%0d clk_en", cyc), 32'(o_clk_en), 32'(e.en));
      chk($sformatf("c%0d div_clk", cyc), 32'(o_div_clk), 32'(e.dclk));
      chk($sformatf("c%0d locked", cyc), 32'(o_locked), 32'(e.lk));
      chk($sformatf("c%0d busy", cyc), 32'(o_busy), 32'(e.bz));
      chk($sformatf("c%0d ack", cyc), 32'(o_cfg_ack), 32'(e.ack));
      chk($sformatf("c%0d err", cyc), 32'(o_cfg_err), 32'(e.err));
    end
  endtask

  task automatic step();
    cmp_one();
    @(posedge i_clk);
    @(negedge i_clk);
    cyc++;
  endtask

  task automatic chk_rst(input string p);
    chk({p, " clk_en"}, 32'(o_clk_en), 0);
    chk({p, " div_clk"}, 32'(o_div_clk), 0);
    chk({p, " locked"}, 32'(o_locked), 0);
    chk({p, " busy"}, 32'(o_busy), 1);
    chk({p, " ack"}, 32'(o_cfg_ack), 0);
    chk({p, " err"}, 32'(o_cfg_err), 0);
  endtask

  initial begin
    i_rst     = 1'b1;
    i_cfg_req = 1'b0;
    i_cfg_div = '0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_rst("rst0");

    // post-reset settle: ratio 2, four pulses, no ack
    i_rst = 1'b0;
    cyc   = 0;
    gen(2, 0, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    gen(2, 0, 4, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (12) step();

    // reconfigure to 5 at cycle 12 (count 0)
    gen(2, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    gen(2, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    gen(5, 0, 20, 1'b0, 1'b1, 1'b0, 1'b0);
    gen(5, 0, 5, 1'b1, 1'b0, 1'b1, 1'b0);
    i_cfg_req = 1'b1;
    i_cfg_div = 8'd5;
    step();
    i_cfg_req = 1'b0;
    repeat (26) step();

    // illegal ratios 1 and 0 at cycles 39 and 42
    gen(5, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    gen(5, 1, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    gen(5, 2, 2, 1'b1, 1'b0, 1'b0, 1'b0);
    gen(5, 4, 1, 1'b1, 1'b0, 1'b0, 1'b1);
    gen(5, 0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    i_cfg_req = 1'b1;
    i_cfg_div = 8'd1;
    step();
    i_cfg_req = 1'b0;
    repeat (2) step();
    i_cfg_req = 1'b1;
    i_cfg_div = 8'd0;
    step();
    i_cfg_req = 1'b0;
    repeat (6) step();

    // change to 3 at cycle 49; request for 7 during LOCK is dropped
    gen(5, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    gen(5, 1, 4, 1'b1, 1'b1, 1'b0, 1'b0);
    gen(3, 0, 12, 1'b0, 1'b1, 1'b0, 1'b0);
    gen(3, 0, 6, 1'b1, 1'b0, 1'b1, 1'b0);
    i_cfg_req = 1'b1;
    i_cfg_div = 8'd3;
    step();
    i_cfg_req = 1'b0;
    repeat (8) step();
    i_cfg_req = 1'b1;
    i_cfg_div = 8'd7;
    step();
    i_cfg_req = 1'b0;
    repeat (13) step();

    // request 9 at cycle 72, reset during DRAIN at cycle 73
    gen(3, 0, 1, 1'b1, 1'b0, 1'b0, 1'b0);
    gen(3, 1, 1, 1'b1, 1'b1, 1'b0, 1'b0);
    i_cfg_req = 1'b1;
    i_cfg_div = 8'd9;
    step();
    i_cfg_req = 1'b0;
    cmp_one();
    i_rst = 1'b1;
    #1;
    chk_rst("rst_async");
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    chk_rst("rst_hold");
    i_rst = 1'b0;
    cyc   = 0;
    gen(2, 0, 8, 1'b0, 1'b1, 1'b0, 1'b0);
    gen(2, 0, 14, 1'b1, 1'b0, 1'b0, 1'b0);
    repeat (22) step();

    chk("sb_drained", 32'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
